spsram_banked: RTL

SPSRAM_BANKED -- requirements
Module: spsram_banked

---
 rtl/spsram_banked.sv | 118 +++++++++++
 1 files changed

// File: rtl/spsram_banked.sv
// Banked single-port SRAM that zero-clears itself after reset or on request.
// Latency: read data and o_rvalid appear one cycle after acceptance; writes take effect at the accepting edge.
// Backpressure: o_ready is low while clearing, and requests presented then are ignored.
module spsram_banked #(
    parameter int BW_DATA  = 32,
    parameter int BW_ADDR  = 5,
    parameter int NUM_BANK = 2
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_req,
    input  logic               i_wen,
    input  logic [BW_ADDR-1:0] i_addr,
    input  logic [BW_DATA-1:0] i_data,
    input  logic               i_init,
    output logic [BW_DATA-1:0] o_data,
    output logic               o_rvalid,
    output logic               o_ready
);

    localparam int BW_BANK    = $clog2(NUM_BANK);
    localparam int BW_IDX     = BW_ADDR - BW_BANK;
    localparam int DEPTH_BANK = 1 << BW_IDX;
    localparam logic [BW_IDX-1:0] IDX_LAST = '1;

    typedef enum logic {S_INIT, S_RUN} state_t;

    state_t               state;
    logic [BW_IDX-1:0]    cnt;
    logic [BW_BANK-1:0]   sel_q;

    logic [BW_BANK-1:0]   req_bank;
    logic [BW_IDX-1:0]    req_idx;
    logic                 acc, acc_wr, acc_rd, clearing;
    logic [BW_IDX-1:0]    bank_idx;
    logic                 bank_we;
    logic [BW_DATA-1:0]   bank_wdat;
    logic [NUM_BANK-1:0]  bank_ce;
    logic [NUM_BANK-1:0][BW_DATA-1:0] bank_rdata;

    assign req_bank = i_addr[BW_ADDR-1 -: BW_BANK];
    assign req_idx  = i_addr[BW_IDX-1:0];

    // A request that coincides with an init pulse is dropped.
    assign acc      = i_req & o_ready & ~i_init;
    assign acc_wr   = acc & i_wen;
    assign acc_rd   = acc & ~i_wen;
    assign clearing = (state == S_INIT);

    assign bank_idx  = clearing ? cnt : req_idx;
    assign bank_we   = clearing | acc_wr;
    assign bank_wdat = clearing ? '0 : i_data;

    for (genvar b = 0; b < NUM_BANK; b++) begin : g_bank
        logic [BW_DATA-1:0] mem [DEPTH_BANK];
        logic [BW_DATA-1:0] rd_q;

        assign bank_ce[b] = clearing | (acc & (req_bank == BW_BANK'(b)));

        always_ff @(posedge i_clk) begin
            if (bank_ce[b] && bank_we) begin
                mem[bank_idx] <= bank_wdat;
            end
        end

        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                rd_q <= '0;
            end else if (bank_ce[b] && !bank_we) begin
                rd_q <= mem[bank_idx];
            end
        end

        assign bank_rdata[b] = rd_q;
    end

    // Bank outputs only change on their own reads, so the mux output holds between reads.
    assign o_data = bank_rdata[sel_q];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= S_INIT;
            cnt      <= '0;
            o_ready  <= 1'b0;
            o_rvalid <= 1'b0;
            sel_q    <= '0;
        end else begin
            o_rvalid <= acc_rd;
            if (acc_rd) begin
                sel_q <= req_bank;
            end
            case (state)
                S_INIT: begin
                    if (cnt == IDX_LAST) begin
                        cnt     <= '0;
                        state   <= S_RUN;
                        o_ready <= 1'b1;
                    end else begin
                        cnt <= cnt + BW_IDX'(1);
                    end
                end
                S_RUN: begin
                    if (i_init) begin
                        cnt     <= '0;
                        state   <= S_INIT;
                        o_ready <= 1'b0;
                    end
                end
                default: begin
                    state   <= S_INIT;
                    cnt     <= '0;
                    o_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule
